// File: rtl/song_play_ctrl_if.sv
// Control bundle between the button front end and the playback controller.
// The slave modport is the controller side; master is the driving side.
interface song_play_ctrl_if;
  logic       play_button;
  logic       next_button;
  logic       song_done;
  logic       play;
  logic [1:0] song;
  logic       reset_player;
  logic       busy;

  modport master (
    output play_button, next_button, song_done,
    input  play, song, reset_player, busy
  );

  modport slave (
    input  play_button, next_button, song_done,
    output play, song, reset_player, busy
  );
endinterface

// File: rtl/song_play_ctrl.sv
// Playback controller for song_reader: play/pause, next-song and timed reader flush.
// Define SONG_PLAY_CTRL_AUTO_ADVANCE_EN to continue to the next song when one ends.
module song_play_ctrl #(
  parameter int NUM_SONGS    = 4,
  parameter int RESET_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  song_play_ctrl_if.slave bus
);

  localparam int CW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(RESET_CYCLES - 1);
  localparam logic [1:0]    SONG_LAST = 2'(NUM_SONGS - 1);

  localparam logic [1:0] PAUSED  = 2'd0;
  localparam logic [1:0] PLAYING = 2'd1;
  localparam logic [1:0] FLUSH   = 2'd2;

  logic [1:0]    state, state_n;
  logic [1:0]    ret, ret_n;
  logic [1:0]    song, song_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          play_q, reset_player_q, busy_q;
  logic [1:0]    next_song;

  assign next_song = (song == SONG_LAST) ? 2'd0 : song + 2'd1;

  always_comb begin
    state_n = state;
    ret_n   = ret;
    song_n  = song;
    cnt_n   = cnt;
    case (state)
      PAUSED: begin
        if (bus.next_button) begin
          state_n = FLUSH;
          song_n  = next_song;
          ret_n   = PAUSED;
          cnt_n   = '0;
        end else if (bus.play_button) begin
          state_n = PLAYING;
        end
      end
      PLAYING: begin
        if (bus.next_button) begin
          state_n = FLUSH;
          song_n  = next_song;
          ret_n   = PLAYING;
          cnt_n   = '0;
        end else if (bus.song_done) begin
          state_n = FLUSH;
          cnt_n   = '0;
`ifdef SONG_PLAY_CTRL_AUTO_ADVANCE_EN
          song_n  = next_song;
          ret_n   = PLAYING;
`else
          ret_n   = PAUSED;
`endif
        end else if (bus.play_button) begin
          state_n = PAUSED;
        end
      end
      FLUSH: begin
        // Inputs are deliberately ignored here; pulses arriving mid-flush are lost.
        if (cnt == CNT_LAST) begin
          state_n = ret;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = PAUSED;
        ret_n   = PAUSED;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= PAUSED;
      ret            <= PAUSED;
      song           <= 2'd0;
      cnt            <= '0;
      play_q         <= 1'b0;
      reset_player_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state          <= state_n;
      ret            <= ret_n;
      song           <= song_n;
      cnt            <= cnt_n;
      play_q         <= (state_n == PLAYING);
      reset_player_q <= (state_n == FLUSH);
      busy_q         <= (state_n == FLUSH);
    end
  end

  assign bus.play         = play_q;
  assign bus.song         = song;
  assign bus.reset_player = reset_player_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_song_play_ctrl.sv
// Directed bench for song_play_ctrl: a vector table plus hand-written flush/wrap/reset sequences.
module tb_song_play_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  song_play_ctrl_if bus ();

  song_play_ctrl #(
    .NUM_SONGS   (4),
    .RESET_CYCLES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       pb;
    logic       nb;
    logic       sd;
    logic       ep;
    logic [1:0] es;
    logic       erp;
    logic       eb;
  } vec_t;

  vec_t vecs[16];

  // A song ending while playing song 2 either advances and keeps playing or rewinds and pauses.
`ifdef SONG_PLAY_CTRL_AUTO_ADVANCE_EN
  localparam logic [1:0] DONE_SONG = 2'd3;
  localparam logic       DONE_PLAY = 1'b1;
`else
  localparam logic [1:0] DONE_SONG = 2'd2;
  localparam logic       DONE_PLAY = 1'b0;
`endif

  function automatic vec_t mk(input logic r, pb, nb, sd, ep, input logic [1:0] es,
                              input logic erp, eb);
    vec_t v;
    v.rst = r; v.pb = pb; v.nb = nb; v.sd = sd;
    v.ep = ep; v.es = es; v.erp = erp; v.eb = eb;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, pb, nb, sd);
    reset           = r;
    bus.play_button = pb;
    bus.next_button = nb;
    bus.song_done   = sd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ep, input logic [1:0] es,
                             input logic erp, eb);
    total++;
    if (bus.play !== ep || bus.song !== es || bus.reset_player !== erp || bus.busy !== eb) begin
      bad++;
      $display("[TB] FAIL %s: got play=%b song=%0d reset_player=%b busy=%b, want play=%b song=%0d reset_player=%b busy=%b",
               name, bus.play, bus.song, bus.reset_player, bus.busy, ep, es, erp, eb);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.play_button = 1'b0;
    bus.next_button = 1'b0;
    bus.song_done   = 1'b0;

    //                rst pb nb sd  play song rp busy
    vecs[0]  = mk(1, 0, 0, 0,  0, 2'd0, 0, 0);          // reset state
    vecs[1]  = mk(0, 0, 0, 0,  0, 2'd0, 0, 0);          // idle paused
    vecs[2]  = mk(0, 0, 0, 1,  0, 2'd0, 0, 0);          // song_done ignored when paused
    vecs[3]  = mk(0, 1, 0, 0,  1, 2'd0, 0, 0);          // play one cycle later
    vecs[4]  = mk(0, 0, 0, 0,  1, 2'd0, 0, 0);
    vecs[5]  = mk(0, 0, 1, 0,  0, 2'd1, 1, 1);          // next: flush cycle 1, new song
    vecs[6]  = mk(0, 1, 0, 0,  0, 2'd1, 1, 1);          // flush cycle 2, play pulse dropped
    vecs[7]  = mk(0, 0, 0, 0,  1, 2'd1, 0, 0);          // play resumes
    vecs[8]  = mk(0, 1, 0, 0,  0, 2'd1, 0, 0);          // pause, no flush
    vecs[9]  = mk(0, 0, 1, 0,  0, 2'd2, 1, 1);          // next while paused
    vecs[10] = mk(0, 0, 0, 0,  0, 2'd2, 1, 1);
    vecs[11] = mk(0, 0, 0, 0,  0, 2'd2, 0, 0);          // stays paused
    vecs[12] = mk(0, 1, 0, 0,  1, 2'd2, 0, 0);
    vecs[13] = mk(0, 0, 0, 1,  0, DONE_SONG, 1, 1);     // song_done -> flush
    vecs[14] = mk(0, 0, 0, 1,  0, DONE_SONG, 1, 1);     // lingering level ignored in flush
    vecs[15] = mk(0, 0, 0, 0,  DONE_PLAY, DONE_SONG, 0, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].pb, vecs[i].nb, vecs[i].sd);
      checkOutput($sformatf("vec%0d", i), vecs[i].ep, vecs[i].es, vecs[i].erp, vecs[i].eb);
    end

    // Repeated next while paused walks 1,2,3 and wraps to 0, never starting playback.
    applyStimulus(1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      logic [1:0] s;
      s = 2'(i % 4);
      applyStimulus(0, 0, 1, 0);
      checkOutput($sformatf("wrap%0d_f1", i), 0, s, 1, 1);
      applyStimulus(0, 0, 0, 0);
      checkOutput($sformatf("wrap%0d_f2", i), 0, s, 1, 1);
      applyStimulus(0, 0, 0, 0);
      checkOutput($sformatf("wrap%0d_end", i), 0, s, 0, 0);
    end

    // All three inputs together while playing song 1: next wins, one flush only.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("setup_song1", 1, 2'd1, 0, 0);
    applyStimulus(0, 1, 1, 1);
    checkOutput("simul_f1", 0, 2'd2, 1, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("simul_f2", 0, 2'd2, 1, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("simul_end", 1, 2'd2, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("simul_hold", 1, 2'd2, 0, 0);

    // Reset during the first flush cycle aborts straight to reset values.
    applyStimulus(0, 0, 1, 0);
    checkOutput("abort_f1", 0, 2'd3, 1, 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("abort_reset", 0, 2'd0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("abort_idle", 0, 2'd0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
